// File: rtl/fitbit_pkg.sv
// fitbit_pkg
//   Shared definitions for the display page scheduler:
//   - state_t : FSM state encodings (IDLE=0, ROTATE=1, HOLD=2, MANUAL=3)
//   - PAGE_*  : page numbers shown on the seven-segment display
//   - next_page() : page advance with wrap from 3 back to 0
package fitbit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROTATE = 2'd1,
    ST_HOLD   = 2'd2,
    ST_MANUAL = 2'd3
  } state_t;

  localparam logic [1:0] PAGE_STEPS = 2'd0;
  localparam logic [1:0] PAGE_DIST  = 2'd1;
  localparam logic [1:0] PAGE_SPEED = 2'd2;
  localparam logic [1:0] PAGE_HAT   = 2'd3;

  // Four pages, so the 2-bit add wraps 3 -> 0 on its own.
  function automatic logic [1:0] next_page(input logic [1:0] p);
    return p + 2'd1;
  endfunction

endpackage

// File: rtl/edge_pulse.sv
// edge_pulse
//   Rising-edge detector for a debounced, clk-synchronous button level.
//   The previous level is held in a register; pulse is high for the single
//   cycle in which level is 1 and the registered history is still 0, so a
//   button held down produces exactly one pulse.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high; clears the history register
//   level - debounced button level
//   pulse - one-cycle press indication
module edge_pulse (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic level_q;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge value of its inputs, independent of
  // statement or process ordering.
  always_ff @(posedge clk) begin
    if (reset) level_q <= 1'b0;
    else       level_q <= level;
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/display_page_scheduler.sv
// display_page_scheduler
//   Chooses which of four activity pages drives the seven-segment display.
//   IDLE    : paused (start=0); page and dwell counter are retained.
//   ROTATE  : page advances every DWELL_SEC seconds.
//   HOLD    : page frozen until the next hold press.
//   MANUAL  : page advances on each next press; after MANUAL_SEC seconds
//             without a press the display returns to ROTATE.
// Configuration:
//   `define MANUAL_NEXT_EN compiles in manual paging (btn_next, MANUAL state).
//   Without it btn_next is ignored and MANUAL is unreachable.
// Ports:
//   clk, reset   - clock (rising edge), synchronous active-high reset
//   start        - level: 1 run, 0 pause
//   sec_tick     - one-cycle pulse per second
//   btn_next     - debounced next-page button level
//   btn_hold     - debounced hold button level
//   step_count, distance, speed_check, hat - 16-bit page sources
//   seg_value    - registered value of the selected page source
//   dp_en        - registered decimal-point enable, 1 on the distance page
//   page         - current page (0 steps, 1 distance, 2 speed, 3 high-activity)
//   state        - current FSM state encoding
module display_page_scheduler
  import fitbit_pkg::*;
#(
  parameter int DWELL_SEC  = 2,
  parameter int MANUAL_SEC = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sec_tick,
  input  logic        btn_next,
  input  logic        btn_hold,
  input  logic [15:0] step_count,
  input  logic [15:0] distance,
  input  logic [15:0] speed_check,
  input  logic [15:0] hat,
  output logic [15:0] seg_value,
  output logic        dp_en,
  output logic [1:0]  page,
  output logic [1:0]  state
);

  localparam logic [3:0] DWELL_LIM = 4'(DWELL_SEC);

  state_t     cur_state;
  logic [3:0] dwell_cnt;
  logic       hold_press;
  logic       next_press;

  edge_pulse u_hold_edge (
    .clk   (clk),
    .reset (reset),
    .level (btn_hold),
    .pulse (hold_press)
  );

  edge_pulse u_next_edge (
    .clk   (clk),
    .reset (reset),
    .level (btn_next),
    .pulse (next_press)
  );

`ifdef MANUAL_NEXT_EN
  localparam logic [3:0] MANUAL_LIM = 4'(MANUAL_SEC);
  logic [3:0] idle_cnt;
`else
  // Manual paging is compiled out; the next-press pulse and MANUAL_SEC are
  // intentionally left without a consumer.
  logic [31:0] unused_manual;
  assign unused_manual = 32'(MANUAL_SEC) ^ {31'd0, next_press};
`endif

  // Priority inside ROTATE/MANUAL: hold press, then next press, then
  // sec_tick. A tick coinciding with a next press is discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= ST_IDLE;
      page      <= PAGE_STEPS;
      dwell_cnt <= 4'd0;
`ifdef MANUAL_NEXT_EN
      idle_cnt  <= 4'd0;
`endif
    end else if (!start) begin
      // Pause: only the state changes, everything else is retained.
      cur_state <= ST_IDLE;
    end else begin
      case (cur_state)
        ST_IDLE: begin
          cur_state <= ST_ROTATE;
          dwell_cnt <= 4'd0;
        end
        ST_ROTATE: begin
          if (hold_press) begin
            cur_state <= ST_HOLD;
`ifdef MANUAL_NEXT_EN
          end else if (next_press) begin
            cur_state <= ST_MANUAL;
            page      <= next_page(page);
            idle_cnt  <= 4'd0;
`endif
          end else if (sec_tick) begin
            if (dwell_cnt + 4'd1 == DWELL_LIM) begin
              page      <= next_page(page);
              dwell_cnt <= 4'd0;
            end else begin
              dwell_cnt <= dwell_cnt + 4'd1;
            end
          end
        end
        ST_HOLD: begin
          if (hold_press) begin
            cur_state <= ST_ROTATE;
            dwell_cnt <= 4'd0;
          end
        end
`ifdef MANUAL_NEXT_EN
        ST_MANUAL: begin
          if (hold_press) begin
            cur_state <= ST_HOLD;
          end else if (next_press) begin
            page     <= next_page(page);
            idle_cnt <= 4'd0;
          end else if (sec_tick) begin
            if (idle_cnt + 4'd1 == MANUAL_LIM) begin
              cur_state <= ST_ROTATE;
              dwell_cnt <= 4'd0;
              idle_cnt  <= 4'd0;
            end else begin
              idle_cnt <= idle_cnt + 4'd1;
            end
          end
        end
`endif
        default: cur_state <= ST_IDLE;
      endcase
    end
  end

  // Display registers follow the registered page, so a page change shows up
  // one cycle later and source changes are tracked with one cycle of delay.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_value <= 16'd0;
      dp_en     <= 1'b0;
    end else begin
      case (page)
        PAGE_STEPS: seg_value <= step_count;
        PAGE_DIST:  seg_value <= distance;
        PAGE_SPEED: seg_value <= speed_check;
        default:    seg_value <= hat;
      endcase
      dp_en <= (page == PAGE_DIST);
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_display_page_scheduler.sv
// tb_display_page_scheduler
//   Directed bench for display_page_scheduler with DWELL_SEC=2, MANUAL_SEC=5.
//   Manual-paging scenarios are exercised when MANUAL_NEXT_EN is defined;
//   otherwise the bench checks that btn_next has no effect.
module tb_display_page_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sec_tick;
  logic        btn_next;
  logic        btn_hold;
  logic [15:0] step_count;
  logic [15:0] distance;
  logic [15:0] speed_check;
  logic [15:0] hat;
  logic [15:0] seg_value;
  logic        dp_en;
  logic [1:0]  page;
  logic [1:0]  state;

  int n_checks = 0;
  int n_fails  = 0;

  logic [15:0] src [4];

  display_page_scheduler #(.DWELL_SEC(2), .MANUAL_SEC(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .sec_tick    (sec_tick),
    .btn_next    (btn_next),
    .btn_hold    (btn_hold),
    .step_count  (step_count),
    .distance    (distance),
    .speed_check (speed_check),
    .hat         (hat),
    .seg_value   (seg_value),
    .dp_en       (dp_en),
    .page        (page),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after
  // the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sec();
    sec_tick = 1'b1;
    step();
    sec_tick = 1'b0;
    step();
  endtask

  task automatic press_hold();
    btn_hold = 1'b1;
    step();
    btn_hold = 1'b0;
    step();
  endtask

  task automatic press_next();
    btn_next = 1'b1;
    step();
    btn_next = 1'b0;
    step();
  endtask

  task automatic check_page(input string tag, input logic [1:0] exp_page);
    check({tag, ".page"}, 32'(page), 32'(exp_page));
    check({tag, ".seg"}, 32'(seg_value), 32'(src[exp_page]));
    check({tag, ".dp"}, 32'(dp_en), 32'(exp_page == 2'd1));
  endtask

  initial begin
    step_count  = 16'd1234;
    distance    = 16'd5678;
    speed_check = 16'd42;
    hat         = 16'd999;
    src[0] = 16'd1234;
    src[1] = 16'd5678;
    src[2] = 16'd42;
    src[3] = 16'd999;
    reset    = 1'b1;
    start    = 1'b0;
    sec_tick = 1'b0;
    btn_next = 1'b0;
    btn_hold = 1'b0;
    step();
    step();
    check("rst.state", 32'(state), 32'd0);
    check("rst.page", 32'(page), 32'd0);
    check("rst.seg", 32'(seg_value), 32'd0);
    check("rst.dp", 32'(dp_en), 32'd0);

    reset = 1'b0;
    step();
    check("pause.state", 32'(state), 32'd0);
    start = 1'b1;
    step();
    check("run.state", 32'(state), 32'd1);

    // Rotation: page after tick k is (k/2) mod 4.
    for (int k = 1; k <= 9; k++) begin
      sec();
      check_page($sformatf("rot%0d", k), 2'((k / 2) % 4));
    end
    // page 0, dwell 1 -> three ticks reach page 2 with dwell 0
    sec(); sec(); sec();
    check_page("rot_p2", 2'd2);

    // Hold freezes the page; a long held level is a single press.
    press_hold();
    check("hold.state", 32'(state), 32'd2);
    for (int k = 0; k < 5; k++) sec();
    check("hold5.state", 32'(state), 32'd2);
    check("hold5.page", 32'(page), 32'd2);
    btn_hold = 1'b1;
    repeat (4) step();
    btn_hold = 1'b0;
    step();
    check("unhold.state", 32'(state), 32'd1);
    sec();
    check("unhold1.page", 32'(page), 32'd2);
    sec();
    check_page("unhold2", 2'd3);

    // Pause at page 3 with dwell 1; resume clears the dwell counter.
    sec();
    start = 1'b0;
    step();
    check("stop.state", 32'(state), 32'd0);
    check("stop.page", 32'(page), 32'd3);
    sec();
    check("stoptick.page", 32'(page), 32'd3);
    start = 1'b1;
    step();
    check("resume.state", 32'(state), 32'd1);
    sec();
    check("resume1.page", 32'(page), 32'd3);
    sec();
    check_page("resume2", 2'd0);

    // Hold and next together act as hold only; next is ignored in HOLD.
    btn_hold = 1'b1;
    btn_next = 1'b1;
    step();
    btn_hold = 1'b0;
    btn_next = 1'b0;
    step();
    check("both.state", 32'(state), 32'd2);
    check("both.page", 32'(page), 32'd0);
    press_next();
    check("holdnext.state", 32'(state), 32'd2);
    check("holdnext.page", 32'(page), 32'd0);
    press_hold();
    check("rehold.state", 32'(state), 32'd1);

`ifdef MANUAL_NEXT_EN
    // Next press from ROTATE enters MANUAL.
    press_next();
    check("man.state", 32'(state), 32'd3);
    check_page("man", 2'd1);
    for (int k = 1; k <= 4; k++) sec();
    check("man4.state", 32'(state), 32'd3);
    sec();
    check("man5.state", 32'(state), 32'd1);
    sec(); sec();
    check("man_rot.page", 32'(page), 32'd2);

    // Next press and tick together with idle counter at 4.
    press_next();
    check("man2.page", 32'(page), 32'd3);
    for (int k = 0; k < 4; k++) sec();
    btn_next = 1'b1;
    sec_tick = 1'b1;
    step();
    btn_next = 1'b0;
    sec_tick = 1'b0;
    step();
    check("coll.state", 32'(state), 32'd3);
    check("coll.page", 32'(page), 32'd0);
    for (int k = 0; k < 4; k++) sec();
    check("coll4.state", 32'(state), 32'd3);
    sec();
    check("coll5.state", 32'(state), 32'd1);
    sec(); sec();
    check("coll_rot.page", 32'(page), 32'd1);

    // Hold from MANUAL.
    press_next();
    check("man3.page", 32'(page), 32'd2);
    press_hold();
    check("manhold.state", 32'(state), 32'd2);
    sec(); sec();
    check("manhold.page", 32'(page), 32'd2);
    press_hold();
    check("manunhold.state", 32'(state), 32'd1);
`else
    // btn_next has no effect in ROTATE.
    press_next();
    check("nonext.state", 32'(state), 32'd1);
    check("nonext.page", 32'(page), 32'd0);
    sec(); sec();
    check("nonext2.page", 32'(page), 32'd1);
    sec(); sec();
    check("nonext4.page", 32'(page), 32'd2);
`endif

    // Reset while in HOLD at page 2.
    press_hold();
    check("prerst.state", 32'(state), 32'd2);
    check("prerst.page", 32'(page), 32'd2);
    reset = 1'b1;
    step();
    check("hrst.state", 32'(state), 32'd0);
    check("hrst.page", 32'(page), 32'd0);
    check("hrst.seg", 32'(seg_value), 32'd0);
    check("hrst.dp", 32'(dp_en), 32'd0);
    reset = 1'b0;
    step();
    check("hrst_run.state", 32'(state), 32'd1);

    // Reset coinciding with the advancing tick discards it and the dwell.
    sec();
    reset    = 1'b1;
    sec_tick = 1'b1;
    step();
    reset    = 1'b0;
    sec_tick = 1'b0;
    step();
    check("rsttick.page", 32'(page), 32'd0);
    check("rsttick.state", 32'(state), 32'd1);
    sec();
    check("rsttick1.page", 32'(page), 32'd0);
    sec();
    check_page("rsttick2", 2'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
